// File: rtl/shift_pkg.sv
// Shared types and constants for the shift command path.
// Command bundle layout matches the barrel_shifter port encoding.
package shift_pkg;

   localparam int DATA_W = 32;
   localparam int AMT_W = 5;

   localparam logic SHIFT_LEFT = 1'b0;
   localparam logic SHIFT_RIGHT = 1'b1;

   typedef struct packed {
      logic sel;
      logic [AMT_W-1:0] amt;
      logic [DATA_W-1:0] data;
   } shift_cmd_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 32-bit logical barrel shifter.
// sel = 0 shifts left, sel = 1 shifts right with zero fill.
module barrel_shifter
   import shift_pkg::*;
(
   input  logic [DATA_W-1:0] data_in,
   input  logic [AMT_W-1:0]  shift_amt,
   input  logic              sel,
   output logic [DATA_W-1:0] data_out
);

   // Select direction; amount 0 passes data through in both modes
   always_comb begin
      data_out = data_in;
      if (sel == SHIFT_RIGHT) begin
         data_out = data_in >> shift_amt;
      end else begin
         data_out = data_in << shift_amt;
      end
   end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command FIFO feeding a barrel shifter, with a registered result
// stage and a count of results consumed downstream.
module shift_cmd_sequencer
   import shift_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_data,
   input  logic [4:0]             in_amt,
   input  logic                   in_sel,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0]       ops_done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   shift_cmd_t mem_q [DEPTH];
   shift_cmd_t cmd_in;
   shift_cmd_t head;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  count_q, count_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]  ops_q, ops_d;
   logic [DATA_W-1:0] shifted;
   logic              push, pop, full, empty, consume;

   assign head = mem_q[rd_ptr_q];

   barrel_shifter u_shift (
      .data_in   (head.data),
      .shift_amt (head.amt),
      .sel       (head.sel),
      .data_out  (shifted)
   );

   // Handshake decode, pointer/count/output/counter next-state
   always_comb begin
      cmd_in = '{sel: in_sel, amt: in_amt, data: in_data};
      full = (count_q == FULL_LVL);
      empty = (count_q == '0);
      push = in_valid && !full;
      consume = out_valid_q && out_ready;
      pop = !empty && (!out_valid_q || out_ready);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d = count_q;
      out_valid_d = out_valid_q;
      out_data_d = out_data_q;
      ops_d = ops_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (push && !pop) begin
         count_d = count_q + LVL_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - LVL_W'(1);
      end

      if (pop) begin
         out_valid_d = 1'b1;
         out_data_d = shifted;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end

      if (consume) ops_d = ops_q + CNT_W'(1);
   end

   // Control and output registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         out_valid_q <= 1'b0;
         out_data_q <= '0;
         ops_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
         ops_q <= ops_d;
      end
   end

   // Command storage; contents survive reset, only pointers clear
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= cmd_in;
   end

   assign in_ready = !full;
   assign out_valid = out_valid_q;
   assign out_data = out_data_q;
   assign level = count_q;
   assign ops_done = ops_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed table-driven bench for shift_cmd_sequencer,
// plus hand sequences for back-to-back, stall, full and reset cases.
module tb_shift_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic        in_sel;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  level;
   logic [15:0] ops_done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  amt;
      logic        sel;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [9];

   shift_cmd_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .ops_done  (ops_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d,
                        input logic [4:0] a, input logic s);
      in_valid = v;
      in_data = d;
      in_amt = a;
      in_sel = s;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      step();
      step();
      rst = 1'b0;
   endtask

   logic [31:0] exp_q [5];
   logic [15:0] ops_base;

   initial begin
      vecs[0] = '{32'h0000001F, 5'd4, 1'b0, 32'h000001F0};
      vecs[1] = '{32'hDEADBEEF, 5'd0, 1'b0, 32'hDEADBEEF};
      vecs[2] = '{32'hDEADBEEF, 5'd0, 1'b1, 32'hDEADBEEF};
      vecs[3] = '{32'h80000000, 5'd31, 1'b1, 32'h00000001};
      vecs[4] = '{32'h00000001, 5'd31, 1'b0, 32'h80000000};
      vecs[5] = '{32'hFFFFFFFF, 5'd16, 1'b0, 32'hFFFF0000};
      vecs[6] = '{32'hFFFFFFFF, 5'd16, 1'b1, 32'h0000FFFF};
      vecs[7] = '{32'h12345678, 5'd4, 1'b1, 32'h01234567};
      vecs[8] = '{32'h12345678, 5'd4, 1'b0, 32'h23456780};

      out_ready = 1'b1;
      do_reset();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_ops", 32'(ops_done), 32'd0);

      // Single commands: 2-edge latency, then handshake
      for (int i = 0; i < 9; i++) begin
         ops_base = ops_done;
         drive(1'b1, vecs[i].data, vecs[i].amt, vecs[i].sel);
         step();
         drive(1'b0, 32'h0, 5'd0, 1'b0);
         chk($sformatf("v%0d_no_bypass", i), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d_level1", i), 32'(level), 32'd1);
         step();
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_data", i), out_data, vecs[i].exp);
         step();
         chk($sformatf("v%0d_ops", i), 32'(ops_done),
             32'(ops_base + 16'd1));
         chk($sformatf("v%0d_clear", i), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d_hold", i), out_data, vecs[i].exp);
      end

      // Back-to-back throughput with out_ready held high
      do_reset();
      exp_q[0] = 32'h00001F00;
      exp_q[1] = 32'h00000001;
      exp_q[2] = 32'h00000000;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: drive(1'b1, 32'h1F, 5'd8, 1'b0);
            1: drive(1'b1, 32'h1F, 5'd4, 1'b1);
            default: drive(1'b1, 32'h1F, 5'd31, 1'b1);
         endcase
         step();
         chk($sformatf("b2b_level%0d", i), 32'(level <= 3'd1), 32'd1);
         if (i >= 1) begin
            chk($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("b2b_data%0d", i), out_data, exp_q[i-1]);
         end
      end
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      step();
      chk("b2b_valid2", 32'(out_valid), 32'd1);
      chk("b2b_data2", out_data, exp_q[2]);
      chk("b2b_level_end", 32'(level), 32'd0);
      step();
      chk("b2b_ops", 32'(ops_done), 32'd3);

      // Stall: 1 in output register plus 4 in FIFO, then drain
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         exp_q[k] = 32'(2 * (k + 1));
         drive(1'b1, 32'(k + 1), 5'd1, 1'b0);
         step();
         chk($sformatf("stall_rdy%0d", k), 32'(in_ready),
             (k < 4) ? 32'd1 : 32'd0);
      end
      chk("stall_level", 32'(level), 32'd4);
      chk("stall_head", out_data, exp_q[0]);
      drive(1'b1, 32'hBAD, 5'd0, 1'b0);
      step();
      chk("stall_refused", 32'(level), 32'd4);
      chk("stall_frozen", out_data, exp_q[0]);
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      out_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         step();
         chk($sformatf("drain%0d", k), out_data, exp_q[k]);
      end
      step();
      chk("drain_empty", 32'(out_valid), 32'd0);
      chk("drain_ops", 32'(ops_done), 32'd5);

      // Reset mid-stream with 3 queued and out_valid set
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'hF0 + 32'(k), 5'd0, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      chk("pre_rst_level", 32'(level), 32'd3);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_data", out_data, 32'd0);
      chk("mrst_level", 32'(level), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      chk("mrst_ops", 32'(ops_done), 32'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("mrst_stale%0d", k), 32'(out_valid), 32'd0);
      end

      // Full with simultaneous pop: push refused, next cycle accepted
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 32'(k + 1), 5'd1, 1'b0);
         step();
      end
      chk("fp_full", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      drive(1'b1, 32'h100, 5'd0, 1'b1);
      step();
      chk("fp_no_push", 32'(level), 32'd3);
      chk("fp_out1", out_data, 32'd4);
      step();
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      chk("fp_push_pop", 32'(level), 32'd3);
      chk("fp_out2", out_data, 32'd6);
      step();
      step();
      chk("fp_out4", out_data, 32'd10);
      step();
      chk("fp_new", out_data, 32'h100);
      chk("fp_level0", 32'(level), 32'd0);
      step();
      chk("fp_done", 32'(out_valid), 32'd0);
      chk("fp_ops", 32'(ops_done), 32'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
